matvec_engine: RTL and testbench

Parametrised successor to the fixed 16×8-bit matrix-vector multiplier. Computes y = A·x + b for an N×N matrix A streamed row-by-row from a synchronous row memory, with vectors x and b captured at start. Adds a start/busy/finish handshake, configurable dimension and element width, and a wrap/saturate result mode. Sits between the row memory (address `A`, data `Q`) and the result consumer reading `vector_y`.

---
 rtl/matvec_pkg.sv | 14 +
 rtl/matvec_row_dot.sv | 26 ++
 rtl/matvec_engine.sv | 81 ++++++++
 tb/tb_matvec_engine.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/matvec_pkg.sv
// matvec_pkg: shared FSM states, result modes and accumulator sizing for matvec_engine
package matvec_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Wide enough for N full-scale products plus one full-scale bias term
    function automatic int acc_width(input int w, input int n);
        return 2 * w + $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/matvec_row_dot.sv
// matvec_row_dot: one row dot product plus bias, wrapped or saturated to W bits
module matvec_row_dot
    import matvec_pkg::*;
#(
    parameter int N = 16,
    parameter int W = 8
) (
    input  logic [N*W-1:0] q_i,
    input  logic [N*W-1:0] x_i,
    input  logic [W-1:0]   b_i,
    input  logic           mode_i,
    output logic [W-1:0]   y_o
);

    localparam int ACC_W = acc_width(W, N);

    logic [ACC_W-1:0] acc;

    // Sum of all N products plus bias, then reduce to W bits by the selected mode
    always_comb begin
        acc = ACC_W'(b_i);
        for (int c = 0; c < N; c++) acc = acc + ACC_W'(q_i[c*W +: W]) * ACC_W'(x_i[c*W +: W]);
        y_o = (mode_i == MODE_SAT && |acc[ACC_W-1:W]) ? {W{1'b1}} : acc[W-1:0];
    end

endmodule

// File: rtl/matvec_engine.sv
// matvec_engine: y = A*x + b with A streamed row-by-row from a one-cycle-latency row memory
module matvec_engine
    import matvec_pkg::*;
#(
    parameter int N = 16,
    parameter int W = 8,
    localparam int AW = $clog2(N)
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic           start,
    input  logic           sat_en,
    input  logic [N*W-1:0] vector_x,
    input  logic [N*W-1:0] vector_b,
    input  logic [N*W-1:0] Q,
    output logic [AW-1:0]  A,
    output logic [N*W-1:0] vector_y,
    output logic           busy,
    output logic           finish
);

    state_t         state_q, state_d;
    logic [AW-1:0]  a_q, a_d, wr_row;
    logic [N*W-1:0] x_q, b_q, y_q;
    logic           sat_q, wr_en;
    logic [W-1:0]   row_y;

    // Q lags A by one cycle, so the row being written is A-1 in ISSUE and A (= N-1) in DRAIN
    assign wr_en  = state_q == DRAIN || (state_q == ISSUE && a_q != '0);
    assign wr_row = state_q == DRAIN ? a_q : a_q - 1'b1;

    matvec_row_dot #(.N(N), .W(W)) u_row_dot (
        .q_i   (Q),
        .x_i   (x_q),
        .b_i   (b_q[wr_row*W +: W]),
        .mode_i(sat_q),
        .y_o   (row_y)
    );

    // Next state and row address
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        case (state_q)
            IDLE:    if (start) state_d = ISSUE;
            ISSUE:   if (a_q == AW'(N - 1)) state_d = DRAIN; else a_d = a_q + 1'b1;
            DRAIN:   state_d = DONE;
            default: begin
                state_d = IDLE;
                a_d     = '0;
            end
        endcase
    end

    // State, address, operand latches and result rows
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            a_q     <= '0;
            x_q     <= '0;
            b_q     <= '0;
            sat_q   <= MODE_WRAP;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            if (state_q == IDLE && start) begin
                x_q   <= vector_x;
                b_q   <= vector_b;
                sat_q <= sat_en;
            end
            if (wr_en) y_q[wr_row*W +: W] <= row_y;
        end
    end

    assign A        = a_q;
    assign vector_y = y_q;
    assign busy     = state_q == ISSUE || state_q == DRAIN;
    assign finish   = state_q == DONE;

endmodule

// File: tb/tb_matvec_engine.sv
// tb_matvec_engine: randomized and directed checks of matvec_engine at several N/W points
module tb_matvec_engine;

    localparam int NG = 4;
    localparam int NS[NG] = '{4, 16, 2, 7};
    localparam int WS[NG] = '{8, 8, 4, 12};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start[NG], sat[NG], busy[NG], fin[NG];
    logic [191:0] vx[NG], vb[NG], q[NG], yw[NG];
    logic [5:0] aw[NG];
    logic [191:0] mem[NG][16];
    int xm[16], bm[16], qm[16][16];
    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NG; g++) begin : g_dut
        localparam int GN = NS[g];
        localparam int GW = WS[g];
        logic [GN*GW-1:0] yy;
        logic [$clog2(GN)-1:0] aa;
        matvec_engine #(.N(GN), .W(GW)) u_dut (
            .CLK     (clk),
            .RST_N   (rst_n),
            .start   (start[g]),
            .sat_en  (sat[g]),
            .vector_x(vx[g][GN*GW-1:0]),
            .vector_b(vb[g][GN*GW-1:0]),
            .Q       (q[g][GN*GW-1:0]),
            .A       (aa),
            .vector_y(yy),
            .busy    (busy[g]),
            .finish  (fin[g])
        );
        assign yw[g] = 192'(yy);
        assign aw[g] = 6'(aa);
    end

    // Synchronous row memory: data for the address seen at an edge appears after it
    always @(posedge clk) for (int k = 0; k < NG; k++) q[k] <= mem[k][aw[k][3:0]];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] getel(input logic [191:0] v, input int i, input int w);
        return 64'((v >> (i * w)) & ((192'(1) << w) - 192'(1)));
    endfunction

    function automatic logic [63:0] expy(input int g, input int r, input bit s);
        longint acc = bm[r];
        longint mx = (longint'(1) << WS[g]) - 1;
        for (int c = 0; c < NS[g]; c++) acc += longint'(qm[r][c]) * longint'(xm[c]);
        return 64'(s ? (acc > mx ? mx : acc) : acc % (mx + 1));
    endfunction

    task automatic rnd(input int g);
        int mx = (1 << WS[g]) - 1;
        for (int c = 0; c < 16; c++) begin
            xm[c] = int'($urandom_range(0, mx));
            bm[c] = int'($urandom_range(0, mx));
            for (int r = 0; r < 16; r++) qm[r][c] = int'($urandom_range(0, mx));
        end
    endtask

    task automatic pack(input int g);
        int w = WS[g];
        vx[g] = '0;
        vb[g] = '0;
        for (int c = 0; c < NS[g]; c++) begin
            vx[g] |= 192'(xm[c]) << (c * w);
            vb[g] |= 192'(bm[c]) << (c * w);
        end
        for (int r = 0; r < NS[g]; r++) begin
            mem[g][r] = '0;
            for (int c = 0; c < NS[g]; c++) mem[g][r] |= 192'(qm[r][c]) << (c * w);
        end
    endtask

    task automatic op(input int g, input bit s);
        int n = NS[g];
        int lat;
        logic [5:0] aseq[16];
        pack(g);
        @(negedge clk);
        sat[g] = s;
        start[g] = 1'b1;
        @(negedge clk);
        start[g] = 1'b0;
        sat[g] = ~s;
        vx[g] = {6{$urandom()}};
        vb[g] = {6{$urandom()}};
        chk("busy_first", 64'(busy[g]), 64'd1);
        lat = 1;
        while (!fin[g] && lat < 200) begin
            if (lat <= n) aseq[lat-1] = aw[g];
            @(negedge clk);
            lat++;
        end
        chk("latency", 64'(lat), 64'(n + 2));
        chk("busy_in_finish", 64'(busy[g]), 64'd0);
        for (int k = 0; k < n; k++) chk("a_seq", 64'(aseq[k]), 64'(k));
        for (int r = 0; r < n; r++) chk("y_row", getel(yw[g], r, WS[g]), expy(g, r, s));
        start[g] = 1'b1;
        @(negedge clk);
        start[g] = 1'b0;
        chk("finish_one_cycle", 64'(fin[g]), 64'd0);
        chk("start_in_done_ignored", 64'(busy[g]), 64'd0);
        chk("a_back_to_zero", 64'(aw[g]), 64'd0);
    endtask

    initial begin
        int nf, f1, f2, i;
        for (int k = 0; k < NG; k++) begin
            start[k] = 1'b0;
            sat[k] = 1'b0;
            vx[k] = '0;
            vb[k] = '0;
            for (int r = 0; r < 16; r++) mem[k][r] = '0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < NG; k++) begin
            chk("rst_busy", 64'(busy[k]), 64'd0);
            chk("rst_finish", 64'(fin[k]), 64'd0);
            chk("rst_a", 64'(aw[k]), 64'd0);
            chk("rst_y", yw[k][63:0], 64'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        for (int c = 0; c < 16; c++) begin
            xm[c] = c + 1;
            bm[c] = 0;
            for (int r = 0; r < 16; r++) qm[r][c] = (r == c) ? 1 : 0;
        end
        op(0, 1'b0);
        for (int r = 0; r < 4; r++) chk("identity", getel(yw[0], r, 8), 64'(r + 1));

        for (int c = 0; c < 16; c++) begin
            xm[c] = c;
            bm[c] = c;
            for (int r = 0; r < 16; r++) qm[r][c] = 1;
        end
        op(1, 1'b0);
        for (int r = 0; r < 16; r++) chk("bias_ones", getel(yw[1], r, 8), 64'((120 + r) % 256));

        for (int c = 0; c < 16; c++) begin
            xm[c] = 255;
            bm[c] = 255;
            for (int r = 0; r < 16; r++) qm[r][c] = 255;
        end
        op(0, 1'b0);
        op(0, 1'b1);
        for (int r = 0; r < 4; r++) chk("overflow_sat", getel(yw[0], r, 8), 64'd255);

        rnd(0);
        pack(0);
        @(negedge clk);
        sat[0] = 1'b0;
        start[0] = 1'b1;
        nf = 0;
        f1 = 0;
        f2 = 0;
        for (int j = 1; j <= 2 * 4 + 8; j++) begin
            @(negedge clk);
            if (j == 4 + 5) start[0] = 1'b0;
            if (fin[0]) begin
                nf++;
                if (nf == 1) f1 = j;
                else if (nf == 2) f2 = j;
            end
        end
        chk("held_start_ops", 64'(nf), 64'd2);
        chk("first_finish", 64'(f1), 64'd6);
        chk("second_finish", 64'(f2), 64'd13);
        for (int r = 0; r < 4; r++) chk("held_start_y", getel(yw[0], r, 8), expy(0, r, 1'b0));

        rnd(0);
        pack(0);
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        i = 0;
        while (aw[0] != 6'd2 && i < 20) begin
            @(negedge clk);
            i++;
        end
        chk("reach_a2", 64'(aw[0]), 64'd2);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy[0]), 64'd0);
        chk("midrst_finish", 64'(fin[0]), 64'd0);
        chk("midrst_a", 64'(aw[0]), 64'd0);
        chk("midrst_y", yw[0][63:0], 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        op(0, 1'b0);

        for (int g = 0; g < NG; g++)
            for (int s = 0; s < 2; s++)
                for (int rep = 0; rep < 2; rep++) begin
                    rnd(g);
                    op(g, s[0]);
                end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
